// File: rtl/uart_ip_memory_mapped_host_fsm.sv
// Host-side initiator for the UART memory-mapped command protocol: sends command and address bytes,
// then for each data slot waits for one responder byte and answers with one host byte.
module uart_ip_memory_mapped_host_fsm #(
    parameter int NUM_BYTES_DATA    = 4,
    parameter int NUM_BYTES_ADDRESS = 1,
    parameter int NUM_BYTES_COMMAND = 1,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [NUM_BYTES_COMMAND*8-1:0] req_cmd,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] req_addr,
    input  logic [NUM_BYTES_DATA*8-1:0]    req_wdata,
    output logic                           rsp_valid,
    output logic [NUM_BYTES_DATA*8-1:0]    rsp_rdata,
    output logic [1:0]                     rsp_status,
    output logic                           busy,
    output logic                           tx_valid,
    output logic [7:0]                     tx_data,
    input  logic                           tx_ready,
    input  logic                           rx_valid,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_error
);
    localparam int DW    = NUM_BYTES_DATA * 8;
    localparam int AW    = NUM_BYTES_ADDRESS * 8;
    localparam int CW    = NUM_BYTES_COMMAND * 8;
    localparam int MAXAC = (NUM_BYTES_ADDRESS > NUM_BYTES_COMMAND) ? NUM_BYTES_ADDRESS : NUM_BYTES_COMMAND;
    localparam int MAXB  = (NUM_BYTES_DATA > MAXAC) ? NUM_BYTES_DATA : MAXAC;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_ADDR = 3'd2,
        WAIT_RX   = 3'd3,
        SEND_DATA = 3'd4,
        DONE      = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cmd_q, cmd_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic last_cmd, last_addr, last_data, tmr_expired;

    assign last_cmd    = (cnt_q == CNT_W'(NUM_BYTES_COMMAND - 1));
    assign last_addr   = (cnt_q == CNT_W'(NUM_BYTES_ADDRESS - 1));
    assign last_data   = (cnt_q == CNT_W'(NUM_BYTES_DATA - 1));
    assign tmr_expired = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a received byte beats a simultaneous timer expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid) state_d = SEND_CMD;
            SEND_CMD:  if (tx_ready && last_cmd) state_d = SEND_ADDR;
            SEND_ADDR: if (tx_ready && last_addr) state_d = WAIT_RX;
            WAIT_RX: begin
                if (rx_valid)         state_d = SEND_DATA;
                else if (tmr_expired) state_d = DONE;
            end
            SEND_DATA: if (tx_ready) state_d = last_data ? DONE : WAIT_RX;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic, purely a function of state and the shift registers
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            SEND_CMD: begin
                tx_valid = 1'b1;
                tx_data  = cmd_q[7:0];
            end
            SEND_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = addr_q[7:0];
            end
            SEND_DATA: begin
                tx_valid = 1'b1;
                tx_data  = wdata_q[7:0];
            end
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

    // Datapath next-state; the timer only runs while in WAIT_RX and is zero on every entry
    always_comb begin
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        tmr_d    = '0;
        if (state_q != IDLE && rx_error) status_d[1] = 1'b1;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d    = req_cmd;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    status_d = 2'b00;
                    cnt_d    = '0;
                end
            end
            SEND_CMD: begin
                if (tx_ready) begin
                    cmd_d = cmd_q >> 8;
                    cnt_d = last_cmd ? '0 : cnt_q + CNT_W'(1);
                end
            end
            SEND_ADDR: begin
                if (tx_ready) begin
                    addr_d = addr_q >> 8;
                    cnt_d  = last_addr ? '0 : cnt_q + CNT_W'(1);
                end
            end
            WAIT_RX: begin
                // New byte enters at the top so the first reply settles in [7:0]
                if (rx_valid)          rdata_d = (rdata_q >> 8) | (DW'(rx_data) << (DW - 8));
                else if (!tmr_expired) tmr_d = tmr_q + TMR_W'(1);
                else                   status_d[0] = 1'b1;
            end
            SEND_DATA: begin
                if (tx_ready) begin
                    wdata_d = wdata_q >> 8;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= 2'b00;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else begin
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
        end
    end

endmodule
